// File: rtl/ftoi_arbiter.sv
// ftoi_arbiter: shares one fixed-latency float->int converter between two requesters.
// Round-robin grant with at most one issue per cycle. A {vld,tag} shift register
// follows each operand through the converter. Results land in a per-requester FIFO,
// and a credit check stops a requester before its FIFO could overflow.
// Optional feature: define FTOI_ARB_STATS_EN to add the stat_iss0, stat_iss1 and
// stat_stall counter ports.
module ftoi_arbiter #(
  parameter int LAT       = 1,  // converter latency, cvt_x sampled -> cvt_y valid (>=1)
  parameter int BUF_DEPTH = 2   // result FIFO entries per requester (power of 2, >=2)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_x,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_y,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_x,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_y,
  output logic [31:0] cvt_x,
  input  logic [31:0] cvt_y
`ifdef FTOI_ARB_STATS_EN
  ,
  output logic [31:0] stat_iss0,
  output logic [31:0] stat_iss1,
  output logic [31:0] stat_stall
`endif
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  // Wide enough for every in-flight slot plus a full FIFO.
  localparam int CRD_W = $clog2(LAT + BUF_DEPTH + 1);

  // Requester-indexed views of the flat ports.
  logic [1:0]        req_valid;
  logic [1:0]        rsp_ready;
  logic [31:0]       req_x [2];

  // Arbitration.
  logic [CRD_W-1:0]  inflight [2];
  logic [1:0]        credit;
  logic [1:0]        elig;
  logic [1:0]        grant;
  logic              issue;
  logic              issue_id;
  logic              last_grant;

  // Converter tracking pipeline. Stage 0 holds the operand the converter sampled last edge.
  logic [LAT-1:0]    pipe_vld;
  logic [LAT-1:0]    pipe_tag;

  // Result FIFOs.
  logic [1:0]        push_req;
  logic [1:0]        pop;
  logic [1:0]        rsp_vld;
  logic [31:0]       rsp_y [2];
  logic [CNT_W-1:0]  fifo_cnt [2];
  logic [PTR_W-1:0]  wr_ptr [2];
  logic [PTR_W-1:0]  rd_ptr [2];
  logic [31:0]       fifo_mem [2][BUF_DEPTH];

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  assign req_x[0]  = req0_x;
  assign req_x[1]  = req1_x;

  // Count how many converter slots each requester currently occupies.
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional update, so no path can infer a latch.
    inflight[0] = '0;
    inflight[1] = '0;
    for (int s = 0; s < LAT; s++) begin
      if (pipe_vld[s]) begin
        inflight[pipe_tag[s]] = inflight[pipe_tag[s]] + CRD_W'(1);
      end
    end
  end

  // A requester is eligible only if its result is sure to find a FIFO slot.
  // Buffered and in-flight results are both counted, so a requester stalled on
  // rsp_ready only blocks itself.
  always_comb begin
    credit = '0;
    elig   = '0;
    for (int i = 0; i < 2; i++) begin
      credit[i] = (inflight[i] + CRD_W'(fifo_cnt[i])) < CRD_W'(BUF_DEPTH);
      elig[i]   = req_valid[i] & credit[i] & ~rst;
    end
  end

  // Round-robin pick. On a tie the requester that was not granted last wins.
  always_comb begin
    grant    = '0;
    grant[0] = elig[0] & (~elig[1] | last_grant);
    grant[1] = elig[1] & (~elig[0] | ~last_grant);
  end

  assign issue      = |grant;
  assign issue_id   = grant[1];
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign cvt_x      = grant[1] ? req_x[1] : (grant[0] ? req_x[0] : 32'h0);

  // Remember the last winner. It only moves when something is issued.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (rst) begin
      last_grant <= 1'b1;
    end else if (issue) begin
      last_grant <= issue_id;
    end
  end

  // Shift {vld,tag} alongside the converter. Reset clears vld, so cvt_y is ignored until new issues arrive.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld <= '0;
      pipe_tag <= '0;
    end else begin
      pipe_vld[0] <= issue;
      pipe_tag[0] <= issue_id;
      for (int s = 1; s < LAT; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        pipe_tag[s] <= pipe_tag[s-1];
      end
    end
  end

  // The last stage delivers cvt_y to the FIFO named by its tag.
  assign push_req[0] = pipe_vld[LAT-1] & ~pipe_tag[LAT-1] & ~rst;
  assign push_req[1] = pipe_vld[LAT-1] &  pipe_tag[LAT-1] & ~rst;

  // FIFO heads drive the response ports. All response outputs are forced low during reset.
  always_comb begin
    rsp_vld  = '0;
    pop      = '0;
    rsp_y[0] = '0;
    rsp_y[1] = '0;
    for (int i = 0; i < 2; i++) begin
      rsp_vld[i] = (fifo_cnt[i] != '0) & ~rst;
      pop[i]     = rsp_vld[i] & rsp_ready[i];
      rsp_y[i]   = rsp_vld[i] ? fifo_mem[i][rd_ptr[i]] : 32'h0;
    end
  end

  assign rsp0_valid = rsp_vld[0];
  assign rsp1_valid = rsp_vld[1];
  assign rsp0_y     = rsp_y[0];
  assign rsp1_y     = rsp_y[1];

  // FIFO pointers and occupancy. Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_cnt[i] <= '0;
        wr_ptr[i]   <= '0;
        rd_ptr[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push_req[i]) begin
          wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        end
        case ({push_req[i], pop[i]})
          2'b10:   fifo_cnt[i] <= fifo_cnt[i] + CNT_W'(1);
          2'b01:   fifo_cnt[i] <= fifo_cnt[i] - CNT_W'(1);
          default: fifo_cnt[i] <= fifo_cnt[i];
        endcase
      end
    end
  end

  // Write converter results into FIFO storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset. Occupancy is reset, and an empty head is masked to zero at the output.
    for (int i = 0; i < 2; i++) begin
      if (push_req[i]) begin
        fifo_mem[i][wr_ptr[i]] <= cvt_y;
      end
    end
  end

`ifdef FTOI_ARB_STATS_EN
  logic any_stall;

  assign any_stall = (req0_valid & ~grant[0]) | (req1_valid & ~grant[1]);

  // Per-requester issue counters and a stall counter (+1 max per cycle). All wrap at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_iss0  <= '0;
      stat_iss1  <= '0;
      stat_stall <= '0;
    end else begin
      stat_iss0  <= stat_iss0  + 32'(grant[0]);
      stat_iss1  <= stat_iss1  + 32'(grant[1]);
      stat_stall <= stat_stall + 32'(any_stall);
    end
  end
`endif

endmodule

// File: tb/tb_ftoi_arbiter.sv
// tb_ftoi_arbiter: directed bench for ftoi_arbiter (LAT=1, BUF_DEPTH=2).
// The converter is modelled as a registered lookup of the operands used here.
// Stats checks are active when FTOI_ARB_STATS_EN is defined.
module tb_ftoi_arbiter;

  localparam int LAT       = 1;
  localparam int BUF_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [31:0] req0_x, rsp0_y, req1_x, rsp1_y, cvt_x;
  logic [31:0] cvt_y = 32'h0;
`ifdef FTOI_ARB_STATS_EN
  logic [31:0] stat_iss0, stat_iss1, stat_stall;
`endif

  int n_vec = 0;
  int n_err = 0;

  ftoi_arbiter #(.LAT(LAT), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_x     (req0_x),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_y     (rsp0_y),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_x     (req1_x),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_y     (rsp1_y),
    .cvt_x      (cvt_x),
    .cvt_y      (cvt_y)
`ifdef FTOI_ARB_STATS_EN
    ,
    .stat_iss0  (stat_iss0),
    .stat_iss1  (stat_iss1),
    .stat_stall (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] cvt_model(input logic [31:0] x);
    case (x)
      32'h3F800000: return 32'd1;
      32'h40000000: return 32'd2;
      32'h40400000: return 32'd3;
      32'h40800000: return 32'd4;
      32'h40A00000: return 32'd5;
      32'h40C00000: return 32'd6;
      32'h40E00000: return 32'd7;
      32'h41000000: return 32'd8;
      32'h41200000: return 32'd10;
      32'h42C80000: return 32'd100;
      32'hC0400000: return 32'hFFFFFFFD;
      32'h3FC00000: return 32'd2;
      32'h00000000: return 32'd0;
      default:      return 32'hDEADBEEF;
    endcase
  endfunction

  // Registered converter, latency 1.
  always @(posedge clk) cvt_y <= cvt_model(cvt_x);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_x     = 32'h0;
    req1_x     = 32'h0;
  endtask

  // One reset cycle. On return the bench is in the first post-reset cycle.
  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
  endtask

  // A result must never be pushed into a full FIFO.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (dut.push_req[0] === 1'b1)
        check("push_room0", 32'(32'(dut.fifo_cnt[0]) < BUF_DEPTH), 32'd1);
      if (dut.push_req[1] === 1'b1)
        check("push_room1", 32'(32'(dut.fifo_cnt[1]) < BUF_DEPTH), 32'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  logic [31:0] d_ops0 [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  logic [31:0] d_exp0 [8] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
  logic [31:0] d_ops1 [4] = '{32'h41200000, 32'h42C80000, 32'hC0400000, 32'h3FC00000};
  logic [31:0] d_exp1 [4] = '{32'd10, 32'd100, 32'hFFFFFFFD, 32'd2};

  initial begin
    logic [11:0] c_g0;
    logic [11:0] c_g1;
    int tx0, tx1, rx0, rx1;

    rst = 1'b1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    idle_inputs();
    tick();

    // Reset state: outputs stay low even though both requesters are valid.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_x     = 32'h40400000;
    req1_x     = 32'h3FC00000;
    #2;
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_req1_ready", 32'(req1_ready), 32'd0);
    check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("rst_rsp0_y", rsp0_y, 32'h0);
    check("rst_rsp1_y", rsp1_y, 32'h0);
    check("rst_cvt_x", cvt_x, 32'h0);
    tick();

    // Single req0 conversion of 3.0, result visible two cycles after the handshake.
    do_reset();
    rsp0_ready = 1'b1;
    req0_valid = 1'b1;
    req0_x     = 32'h40400000;
    #2;
    check("a_req0_ready", 32'(req0_ready), 32'd1);
    check("a_cvt_x", cvt_x, 32'h40400000);
    tick();
    idle_inputs();
    #2;
    check("a_c1_rsp0_valid", 32'(rsp0_valid), 32'd0);
    tick();
    #2;
    check("a_c2_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check("a_c2_rsp0_y", rsp0_y, 32'h00000003);
    tick();
    #2;
    check("a_c3_rsp0_valid", 32'(rsp0_valid), 32'd0);

    // Both requesters valid every cycle: grants alternate, starting with req0.
    do_reset();
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req0_valid = (k < 6);
      req1_valid = (k < 6);
      req0_x     = 32'hC0400000;
      req1_x     = 32'h3FC00000;
      #2;
      check($sformatf("b_req0_ready_k%0d", k), 32'(req0_ready), 32'((k < 6) && (k % 2 == 0)));
      check($sformatf("b_req1_ready_k%0d", k), 32'(req1_ready), 32'((k < 6) && (k % 2 == 1)));
      check($sformatf("b_rsp0_valid_k%0d", k), 32'(rsp0_valid), 32'((k >= 2) && (k % 2 == 0)));
      check($sformatf("b_rsp1_valid_k%0d", k), 32'(rsp1_valid), 32'((k >= 3) && (k % 2 == 1)));
      if (k >= 2 && k % 2 == 0) check($sformatf("b_rsp0_y_k%0d", k), rsp0_y, 32'hFFFFFFFD);
      if (k >= 3 && k % 2 == 1) check($sformatf("b_rsp1_y_k%0d", k), rsp1_y, 32'h00000002);
      tick();
    end

    // req1 stalled on rsp1_ready: two issues, then only req0 (credit-limited) until req1 pops.
    do_reset();
    c_g0 = 12'b0101_1011_0101;
    c_g1 = 12'b1000_0000_1010;
    rsp0_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      req0_x     = 32'h40400000;
      req1_x     = 32'h3FC00000;
      rsp1_ready = (k >= 10);
      #2;
      check($sformatf("c_req0_ready_k%0d", k), 32'(req0_ready), 32'(c_g0[k]));
      check($sformatf("c_req1_ready_k%0d", k), 32'(req1_ready), 32'(c_g1[k]));
      if (k >= 10) begin
        check($sformatf("c_rsp1_valid_k%0d", k), 32'(rsp1_valid), 32'd1);
        check($sformatf("c_rsp1_y_k%0d", k), rsp1_y, 32'h00000002);
      end
      tick();
    end
    idle_inputs();
    rsp1_ready = 1'b1;
    for (int k = 0; k < 6; k++) tick();

    // Ordering with FIFOs filled while both response sides are held off, then drained.
    do_reset();
    tx0 = 0; tx1 = 0; rx0 = 0; rx1 = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      req0_valid = (tx0 < 8);
      req1_valid = (tx1 < 4);
      req0_x = 32'h0;
      req1_x = 32'h0;
      if (tx0 < 8) req0_x = d_ops0[tx0];
      if (tx1 < 4) req1_x = d_ops1[tx1];
      rsp0_ready = (cyc >= 6);
      rsp1_ready = (cyc >= 6) && (cyc % 3 != 0);
      #2;
      if (rsp0_valid && rsp0_ready) begin
        if (rx0 < 8) check($sformatf("d_rsp0_%0d", rx0), rsp0_y, d_exp0[rx0]);
        rx0++;
      end
      if (rsp1_valid && rsp1_ready) begin
        if (rx1 < 4) check($sformatf("d_rsp1_%0d", rx1), rsp1_y, d_exp1[rx1]);
        rx1++;
      end
      if (req0_valid && req0_ready) tx0++;
      if (req1_valid && req1_ready) tx1++;
      tick();
    end
    check("d_count0", 32'(rx0), 32'd8);
    check("d_count1", 32'(rx1), 32'd4);

    // Reset mid-operation: buffered and in-flight results are discarded.
    do_reset();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    req1_valid = 1'b1;
    req1_x     = 32'h3FC00000;
    #2;
    check("e_req1_ready", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1;
    req0_x     = 32'h40400000;
    #2;
    check("e_req0_ready", 32'(req0_ready), 32'd1);
    tick();
    rst        = 1'b1;
    req1_valid = 1'b1;
    #2;
    check("e_rst_req0_ready", 32'(req0_ready), 32'd0);
    check("e_rst_req1_ready", 32'(req1_ready), 32'd0);
    check("e_rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("e_rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("e_rst_rsp0_y", rsp0_y, 32'h0);
    check("e_rst_rsp1_y", rsp1_y, 32'h0);
    check("e_rst_cvt_x", cvt_x, 32'h0);
    tick();
    rst = 1'b0;
    idle_inputs();
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #2;
      check($sformatf("e_post_rsp0_valid_k%0d", k), 32'(rsp0_valid), 32'd0);
      check($sformatf("e_post_rsp1_valid_k%0d", k), 32'(rsp1_valid), 32'd0);
      tick();
    end

`ifdef FTOI_ARB_STATS_EN
    // Counters: 5 req0 issues, 3 req1 issues, 2 stalled cycles (the two contested ones).
    begin
      logic [13:0] s_v0;
      logic [13:0] s_v1;
      s_v0 = 14'b10100010001011;
      s_v1 = 14'b00001000100011;
      do_reset();
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      #2;
      check("s_iss0_rst", stat_iss0, 32'd0);
      check("s_iss1_rst", stat_iss1, 32'd0);
      check("s_stall_rst", stat_stall, 32'd0);
      for (int k = 0; k < 14; k++) begin
        req0_valid = s_v0[k];
        req1_valid = s_v1[k];
        req0_x     = 32'h40400000;
        req1_x     = 32'h3FC00000;
        tick();
      end
      idle_inputs();
      #2;
      check("s_iss0", stat_iss0, 32'd5);
      check("s_iss1", stat_iss1, 32'd3);
      check("s_stall", stat_stall, 32'd2);
    end
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
